// File: rtl/peak_dpu_iss_buf.sv
// peak_dpu_iss_buf: dual-in/dual-out circular issue buffer between the decoder and the dispatch hazard checker
module peak_dpu_iss_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_dec_vld0,
    input  logic [WIDTH-1:0] i_dec_instr0,
    input  logic             i_dec_vld1,
    input  logic [WIDTH-1:0] i_dec_instr1,
    output logic             o_dec_rdy,
    output logic             o_instr0_vld,
    output logic [WIDTH-1:0] o_instr0,
    output logic             o_instr1_vld,
    output logic [WIDTH-1:0] o_instr1,
    input  logic             i_instr0_cannot_iss,
    input  logic             i_instr1_cannot_iss,
    output logic [AW:0]      o_buf_cnt
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head, r_tail;
    logic [AW:0]      r_cnt;
    logic [AW-1:0]    w_head1, w_tail1;
    logic [1:0]       w_push_n, w_pop_n;
    assign w_head1      = r_head + AW'(1);
    assign w_tail1      = r_tail + AW'(1);
    // Readiness looks only at the registered count, keeping cannot_iss off the dec_rdy path
    assign o_dec_rdy    = r_cnt <= (AW+1)'(DEPTH - 2);
    assign o_instr0_vld = r_cnt >= (AW+1)'(1);
    assign o_instr1_vld = r_cnt >= (AW+1)'(2);
    assign o_instr0     = r_mem[r_head];
    assign o_instr1     = r_mem[w_head1];
    assign o_buf_cnt    = r_cnt;
    always_comb begin
        w_push_n = !(o_dec_rdy && i_dec_vld0) ? 2'd0 : i_dec_vld1 ? 2'd2 : 2'd1;
        w_pop_n  = (!o_instr0_vld || i_instr0_cannot_iss) ? 2'd0 :
                   (!o_instr1_vld || i_instr1_cannot_iss) ? 2'd1 : 2'd2;
    end
    always_ff @(posedge clk) begin
        if (w_push_n != 2'd0 && !i_flush) r_mem[r_tail] <= i_dec_instr0;
        if (w_push_n == 2'd2 && !i_flush) r_mem[w_tail1] <= i_dec_instr1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            r_head <= r_head + AW'(w_pop_n);
            r_tail <= r_tail + AW'(w_push_n);
            r_cnt  <= r_cnt + (AW+1)'(w_push_n) - (AW+1)'(w_pop_n);
        end
    end
endmodule

// File: tb/tb_peak_dpu_iss_buf.sv
// tb_peak_dpu_iss_buf: directed scenarios plus random traffic checked against a queue-based FIFO model
module tb_peak_dpu_iss_buf;
    logic        clk = 0, rst = 1, flush = 0;
    logic        dec_vld0 = 0, dec_vld1 = 0, c0 = 0, c1 = 0;
    logic [63:0] dec_instr0 = '0, dec_instr1 = '0;
    logic        dec_rdy, instr0_vld, instr1_vld;
    logic [63:0] instr0, instr1;
    logic [3:0]  buf_cnt;
    logic [63:0] q[$];
    int          n_chk = 0, n_fail = 0;

    peak_dpu_iss_buf dut (
        .clk(clk), .rst(rst), .i_flush(flush),
        .i_dec_vld0(dec_vld0), .i_dec_instr0(dec_instr0),
        .i_dec_vld1(dec_vld1), .i_dec_instr1(dec_instr1),
        .o_dec_rdy(dec_rdy),
        .o_instr0_vld(instr0_vld), .o_instr0(instr0),
        .o_instr1_vld(instr1_vld), .o_instr1(instr1),
        .i_instr0_cannot_iss(c0), .i_instr1_cannot_iss(c1),
        .o_buf_cnt(buf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        int sz = q.size();
        chk("buf_cnt", 64'(buf_cnt), 64'(sz));
        chk("dec_rdy", 64'(dec_rdy), 64'(8 - sz >= 2));
        chk("instr0_vld", 64'(instr0_vld), 64'(sz >= 1));
        chk("instr1_vld", 64'(instr1_vld), 64'(sz >= 2));
        if (sz >= 1) chk("instr0", instr0, q[0]);
        if (sz >= 2) chk("instr1", instr1, q[1]);
    endtask

    task automatic step(input bit f, input bit v0, input logic [63:0] d0,
                        input bit v1, input logic [63:0] d1, input bit k0, input bit k1);
        int sz, pop;
        bit rdy;
        @(negedge clk);
        check_state();
        flush = f; dec_vld0 = v0; dec_instr0 = d0; dec_vld1 = v1; dec_instr1 = d1; c0 = k0; c1 = k1;
        sz  = q.size();
        rdy = (8 - sz) >= 2;
        pop = (sz < 1 || k0) ? 0 : (sz < 2 || k1) ? 1 : 2;
        if (f) q.delete();
        else begin
            repeat (pop) void'(q.pop_front());
            if (rdy && v0) begin
                q.push_back(d0);
                if (v1) q.push_back(d1);
            end
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_state();
        @(negedge clk);
        rst = 0;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 64'hA, 1, 64'hB, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 64'hA1, 1, 64'hB1, 1, 1);
        step(0, 1, 64'hC1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 64'h100, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 64'h200 + 64'(2*i), 1, 64'h201 + 64'(2*i), 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 64'h300, 1, 64'h301, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 64'h400 + 64'(2*i), 1, 64'h401 + 64'(2*i), 0, 1);
        step(0, 1, 64'h500, 1, 64'h501, 0, 1);
        step(0, 1, 64'h600, 0, 0, 1, 1);
        step(1, 1, 64'h700, 1, 64'h701, 0, 0);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, rnd64(),
                 $urandom_range(0, 1) == 1, rnd64(), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        step(1, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, rnd64(), 1, rnd64(), 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        check_state();
        #2 rst = 1;
        #1;
        chk("async_instr0_vld", 64'(instr0_vld), 64'(0));
        chk("async_instr1_vld", 64'(instr1_vld), 64'(0));
        chk("async_buf_cnt", 64'(buf_cnt), 64'(0));
        chk("async_dec_rdy", 64'(dec_rdy), 64'(1));
        q.delete();
        flush = 0; dec_vld0 = 0; dec_vld1 = 0; c0 = 0; c1 = 0;
        @(negedge clk);
        rst = 0;
        step(0, 1, 64'hDEAD, 1, 64'hBEEF, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_state();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
